simon_round_core: RTL
=====================

SIMON_ROUND_CORE -- requirements
Module: simon_round_core

Interface
REQ-001 Parameter ROUNDS, default 32, SHALL be the number of Feistel rounds per block; legal range 1..32.
REQ-002 Parameter WORD, default 16, SHALL be the half-block width; only 16 is supported (Simon 32/64).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request encryption of plaintext; sampled only in IDLE.
REQ-006 plaintext  input  32  SHALL be the block to encrypt, {x,y} with x = [31:16]; captured on start acceptance.
REQ-007 round_key  input  16  SHALL be the current round key, produced by the key generator.
REQ-008 rk_valid  input  1  SHALL indicate round_key is valid this cycle.
REQ-009 rk_ready  output  1  SHALL indicate the core consumes round_key this cycle when rk_valid=1.
REQ-010 round_idx  output  5  SHALL give the index of the round to be executed next (0..ROUNDS-1).
REQ-011 ciphertext  output  32  SHALL hold the encrypted block {x,y}.
REQ-012 busy  output  1  SHALL be high in RUN and DONE.
REQ-013 done  output  1  SHALL pulse high for exactly one cycle when ciphertext becomes valid.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; encoding is free.
REQ-015 In IDLE, start=1 SHALL load x,y from plaintext, clear round_idx to 0 and enter RUN on the next edge.
REQ-016 In RUN, rk_ready SHALL be 1; elsewhere it SHALL be 0.
REQ-017 A round SHALL execute only on a cycle with rk_ready=1 and rk_valid=1 (a handshake).
REQ-018 Round update: x <= y ^ f(x) ^ round_key; y <= x; f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x), all 16-bit rotates.
REQ-019 A RUN cycle with rk_valid=0 SHALL stall: x, y and round_idx are unchanged.
REQ-020 round_idx SHALL increment by 1 per handshake; the handshake at round_idx=ROUNDS-1 SHALL enter DONE and leave round_idx at ROUNDS-1 (no wrap).
REQ-021 On entry to DONE, ciphertext SHALL equal the final {x,y}, done=1 for that one cycle, then the FSM returns to IDLE.
REQ-022 Latency with rk_valid tied high: done SHALL assert exactly ROUNDS+1 cycles after the edge that accepts start (33 cycles for the default).
REQ-023 ciphertext SHALL hold its value through IDLE until the next DONE; it SHALL NOT show intermediate round state.
REQ-024 start while busy (RUN or DONE) SHALL be ignored; there is no queueing.
REQ-025 start=1 in the IDLE cycle right after DONE SHALL be accepted normally (back-to-back blocks).
REQ-026 rk_valid in IDLE or DONE SHALL have no effect on state.
REQ-027 Changes to plaintext after acceptance SHALL NOT affect the running block.

Reset
REQ-028 reset=0 SHALL immediately, without a clock, force IDLE, x=y=0, round_idx=0, ciphertext=0, busy=0, done=0, rk_ready=0.
REQ-029 Reset asserted mid-RUN SHALL abort the block; no done is produced for it.
REQ-030 After release, the first start SHALL be accepted on the first rising edge at which reset=1.

Verification
REQ-031 Known answer: key 64'h1918111009080100 into the key generator, round_key/rk_valid driven from it, plaintext 32'h65656877 -> one done pulse, ciphertext 32'hc69be9bb.
REQ-032 Latency: rk_valid tied high with a model key schedule, start pulse -> done exactly 33 cycles later and busy high for 33 cycles.
REQ-033 Stall: rk_valid deasserted for 5 cycles at round_idx=10 -> round_idx frozen at 10, done 38 cycles after start, ciphertext still 32'hc69be9bb.
REQ-034 Busy start: start pulsed at round_idx=3 with a different plaintext -> ignored, result unchanged, single done.
REQ-035 Reset mid-run: reset=0 at round_idx=20 -> all outputs zero asynchronously, no done; a following full run yields correct ciphertext.
REQ-036 Back-to-back: start held high through DONE -> second block accepted the cycle after done, two done pulses 34 cycles apart.

Source files
------------

// File: rtl/simon_round_core.sv
// Iterative Simon 32/64 encryption core: one Feistel round per round-key handshake.
// Round keys are supplied externally by a key generator via round_key/rk_valid/rk_ready.
module simon_round_core #(
   parameter int ROUNDS = 32,
   parameter int WORD   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2*WORD-1:0] plaintext,
   input  logic [WORD-1:0]   round_key,
   input  logic              rk_valid,
   output logic              rk_ready,
   output logic [4:0]        round_idx,
   output logic [2*WORD-1:0] ciphertext,
   output logic              busy,
   output logic              done,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

   state_t          state_q;
   state_t          state_d;
   logic [WORD-1:0] x_q;
   logic [WORD-1:0] y_q;
   logic [WORD-1:0] x_next;
   logic            fire;
   logic            last_round;

   function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int n);
      return (v << n) | (v >> (WORD - n));
   endfunction

   // Handshake: round_key is consumed on any cycle where rk_ready and rk_valid are both high;
   // rk_ready is high exactly while in RUN, and a low rk_valid simply stalls the round.
   assign rk_ready   = (state_q == RUN);
   assign fire       = rk_ready & rk_valid;
   assign last_round = (round_idx == LAST_IDX);
   assign x_next     = y_q ^ ((rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2)) ^ round_key;

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign fsm_state = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (fire && last_round) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ciphertext is written only by the final round so it never shows intermediate state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q        <= '0;
         y_q        <= '0;
         round_idx  <= '0;
         ciphertext <= '0;
      end else if (state_q == IDLE && start) begin
         x_q       <= plaintext[2*WORD-1:WORD];
         y_q       <= plaintext[WORD-1:0];
         round_idx <= '0;
      end else if (fire) begin
         x_q <= x_next;
         y_q <= x_q;
         if (last_round) begin
            ciphertext <= {x_next, x_q};
         end else begin
            round_idx <= round_idx + 5'd1;
         end
      end
   end

endmodule
